// File: rtl/pixel_pack_writer_if.sv
// Pixel stream in, packed line-buffer writes out.
// slave = packer side, master = producer/line buffer side.
interface pixel_pack_writer_if #(
  parameter int PIX_W  = 2,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [PIX_W-1:0]  in_pixel;
  logic              in_last;
  logic              in_ready;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  logic              line_done;
  logic              err_overflow;

  modport slave (
    input  in_valid, in_pixel, in_last, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data,
    output line_done, err_overflow
  );

  modport master (
    output in_valid, in_pixel, in_last, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data,
    input  line_done, err_overflow
  );
endinterface

// File: rtl/pixel_pack_writer.sv
// Packs 2-bit pixels LSB-first into words and writes them to the line buffer.
// Ports: clk, reset (sync, active-high), bus (pixel in / word write out).
module pixel_pack_writer #(
  parameter int              PIX_W      = 2,
  parameter int              WORD_W     = 32,
  parameter int              ADDR_W     = 6,
  parameter int              LINE_WORDS = 40,
  parameter logic [PIX_W-1:0] PAD       = '0
) (
  input logic                 clk,
  input logic                 reset,
  pixel_pack_writer_if.slave  bus
);
  localparam int PPW = WORD_W / PIX_W;
  localparam int CW  = $clog2(PPW);
  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(LINE_WORDS - 1);
  localparam logic [CW-1:0]     END_CNT  = CW'(PPW - 1);

  logic [WORD_W-1:0] pack_q, pack_d;
  logic [WORD_W-1:0] ins_c, word_c;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wv_q, wv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              ld_q, ld_d;
  logic              err_q, err_d;
  logic              rdy, acc, xfer, done;

  assign rdy  = !wv_q || bus.wr_ready;
  assign acc  = bus.in_valid && rdy;
  assign xfer = wv_q && bus.wr_ready;
  assign done = acc && (cnt_q == END_CNT || bus.in_last);

  // ins_c: pack with the incoming pixel dropped in its slot.
  // word_c: same, but every slot above it forced to PAD.
  always_comb begin
    ins_c  = pack_q;
    word_c = pack_q;
    for (int i = 0; i < PPW; i++) begin
      if (i == int'(cnt_q)) begin
        ins_c[i*PIX_W +: PIX_W]  = bus.in_pixel;
        word_c[i*PIX_W +: PIX_W] = bus.in_pixel;
      end else if (i > int'(cnt_q)) begin
        word_c[i*PIX_W +: PIX_W] = PAD;
      end
    end
  end

  always_comb begin
    pack_d = pack_q;
    cnt_d  = cnt_q;
    wv_d   = wv_q;
    addr_d = addr_q;
    data_d = data_q;
    last_d = last_q;
    err_d  = err_q;
    ld_d   = xfer && last_q;
    if (acc) begin
      pack_d = ins_c;
      cnt_d  = cnt_q + 1'b1;
    end
    if (xfer) begin
      wv_d = 1'b0;
      if (last_q || addr_q == END_ADDR) addr_d = '0;
      else addr_d = addr_q + 1'b1;
      if (!last_q && addr_q == END_ADDR) err_d = 1'b1;
    end
    if (done) begin
      pack_d = '0;
      cnt_d  = '0;
      wv_d   = 1'b1;
      data_d = word_c;
      last_d = bus.in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q <= '0;
      cnt_q  <= '0;
      wv_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      ld_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pack_q <= pack_d;
      cnt_q  <= cnt_d;
      wv_q   <= wv_d;
      addr_q <= addr_d;
      data_q <= data_d;
      last_q <= last_d;
      ld_q   <= ld_d;
      err_q  <= err_d;
    end
  end

  assign bus.in_ready     = rdy;
  assign bus.wr_valid     = wv_q;
  assign bus.wr_addr      = addr_q;
  assign bus.wr_data      = data_q;
  assign bus.line_done    = ld_q;
  assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_pixel_pack_writer.sv
// Randomized bench for pixel_pack_writer against a pixel-list model.
// Drives on posedge+1, observes on negedge.
module tb_pixel_pack_writer;
  localparam int LW = 40;

  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  pixel_pack_writer_if #(.PIX_W(2), .WORD_W(32), .ADDR_W(6)) bus ();

  pixel_pack_writer #(
    .PIX_W(2), .WORD_W(32), .ADDR_W(6),
    .LINE_WORDS(LW), .PAD(2'b00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    bit          last;
  } word_t;

  logic [1:0]  pix_q[$];
  word_t       wq[$];
  int          widx = 0;
  bit          exp_ld = 0;
  bit          exp_err = 0;
  bit          stall_prev = 0;
  logic [5:0]  st_addr;
  logic [31:0] st_data;
  int          n_xfers = 0;
  int          n_lines = 0;
  logic [31:0] last_data;
  logic [5:0]  last_addr;

  function automatic logic [31:0] pack_word();
    logic [31:0] d = 0;
    for (int k = 0; k < 16; k++)
      if (k < pix_q.size()) d += 32'(pix_q[k]) * (32'd1 << (2 * k));
    return d;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      pix_q.delete();
      wq.delete();
      widx = 0;
      exp_ld = 0;
      exp_err = 0;
      stall_prev = 0;
    end else begin
      check("in_ready", bus.in_ready, (wq.size() == 0) || bus.wr_ready);
      check("wr_valid", bus.wr_valid, wq.size() != 0);
      check("line_done", bus.line_done, exp_ld);
      check("err_overflow", bus.err_overflow, exp_err);
      if (bus.line_done) n_lines++;
      if (stall_prev) begin
        check("stall_addr", bus.wr_addr, st_addr);
        check("stall_data", bus.wr_data, st_data);
      end
      stall_prev = bus.wr_valid && !bus.wr_ready;
      st_addr = bus.wr_addr;
      st_data = bus.wr_data;
      exp_ld = 0;
      if (bus.wr_valid && bus.wr_ready && wq.size() > 0) begin
        word_t w;
        w = wq.pop_front();
        check("wr_addr", bus.wr_addr, widx);
        check("wr_data", bus.wr_data, w.data);
        n_xfers++;
        last_data = bus.wr_data;
        last_addr = bus.wr_addr;
        if (w.last) begin
          exp_ld = 1;
          widx = 0;
        end else if (widx == LW - 1) begin
          exp_err = 1;
          widx = 0;
        end else begin
          widx++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        pix_q.push_back(bus.in_pixel);
        if (pix_q.size() == 16 || bus.in_last) begin
          wq.push_back('{data: pack_word(), last: bus.in_last});
          pix_q.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    bus.in_valid = 0;
    bus.wr_ready = 0;
    tick();
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_wr_valid", bus.wr_valid, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_line_done", bus.line_done, 0);
    check("rst_err", bus.err_overflow, 0);
    tick();
    reset = 0;
  endtask

  // mode 0: random pixels, 1: 0,1,2,3 repeating, 2..5: constant mode-2
  task automatic send(input int n, input int mode, input bit with_last,
                      input int vpct, input int rpct,
                      input int st_at, input int st_len,
                      output int cyc);
    int  i = 0;
    bit  a;
    cyc = 0;
    while (i < n) begin
      bus.in_valid = ($urandom_range(99) < vpct);
      case (mode)
        0: bus.in_pixel = 2'($urandom_range(3));
        1: bus.in_pixel = 2'(i % 4);
        default: bus.in_pixel = 2'(mode - 2);
      endcase
      bus.in_last = with_last && (i == n - 1);
      if (cyc >= st_at && cyc < st_at + st_len) bus.wr_ready = 0;
      else bus.wr_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      a = bus.in_valid && bus.in_ready;
      tick();
      cyc++;
      if (a) i++;
      if (cyc > n * 40 + 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.wr_ready = 1;
    repeat (4) tick();
  endtask

  int cyc, x0, l0;

  initial begin
    bus.in_valid = 0;
    bus.in_pixel = 0;
    bus.in_last = 0;
    bus.wr_ready = 0;
    do_reset();

    x0 = n_xfers;
    send(16, 1, 0, 100, 100, 0, 0, cyc);
    check("t1_cycles", cyc, 16);
    check("t1_writes", n_xfers - x0, 1);
    check("t1_data", last_data, 32'hE4E4E4E4);
    check("t1_addr", last_addr, 0);

    x0 = n_xfers;
    l0 = n_lines;
    send(3, 5, 1, 100, 100, 0, 0, cyc);
    check("t2_data", last_data, 32'h0000003F);
    check("t2_lines", n_lines - l0, 1);
    send(1, 4, 1, 100, 100, 0, 0, cyc);
    check("t2_next_addr", last_addr, 0);
    check("t2_single", last_data, 32'h2);

    x0 = n_xfers;
    l0 = n_lines;
    send(640, 3, 1, 100, 100, 0, 0, cyc);
    check("t3_writes", n_xfers - x0, 40);
    check("t3_data", last_data, 32'h55555555);
    check("t3_addr", last_addr, 39);
    check("t3_lines", n_lines - l0, 1);
    check("t3_err", bus.err_overflow, 0);
    check("t3_cycles", cyc, 640);

    x0 = n_xfers;
    send(24, 0, 1, 100, 100, 16, 5, cyc);
    check("t4_writes", n_xfers - x0, 2);

    send(16, 0, 1, 100, 100, 0, 0, cyc);
    send(16, 0, 0, 100, 100, 0, 0, cyc);
    check("t4b_addr", last_addr, 0);

    do_reset();
    x0 = n_xfers;
    send(656, 0, 0, 100, 100, 0, 0, cyc);
    check("t5_writes", n_xfers - x0, 41);
    check("t5_wrap_addr", last_addr, 0);
    check("t5_err", bus.err_overflow, 1);
    send(20, 0, 0, 80, 70, 0, 0, cyc);
    check("t5_err_sticky", bus.err_overflow, 1);

    do_reset();
    x0 = n_xfers;
    send(7, 0, 0, 100, 100, 0, 0, cyc);
    do_reset();
    check("t6_no_write", n_xfers - x0, 0);
    send(16, 4, 0, 100, 100, 0, 0, cyc);
    check("t6_data", last_data, 32'hAAAAAAAA);
    check("t6_addr", last_addr, 0);

    do_reset();
    for (int k = 0; k < 8; k++)
      send($urandom_range(1, 120), 0, 1, $urandom_range(30, 100),
           $urandom_range(20, 100), 0, 0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
